// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - conversion request, honoured only when idle
//   bin   - WIDTH-bit binary value captured when start is accepted
//   busy  - high while shifting
//   done  - one-cycle pulse when bcd carries a new result
//   bcd   - packed BCD result, digit 0 in bits [3:0]
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] scr, adj, nxt;
  logic [CW-1:0]       cnt;
  // Digits are corrected independently; no carry crosses a digit boundary.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = scr[4*d+:4] >= 4'd5 ? scr[4*d+:4] + 4'd3 : scr[4*d+:4];
  end
  // Shift the corrected digits left, pulling in the binary MSB; the top bit drops out.
  assign nxt = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      scr   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh    <= bin;
          scr   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          scr <= nxt;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done;
  logic [11:0] bcd;
  int n_cmp = 0;
  int n_err = 0;
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] v, input logic [11:0] exp);
    int lat, nb;
    bin = v;
    start = 1'b1;
    lat = 0;
    nb = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (busy) nb++;
      if (busy && done) check("busy_and_done", 1, 0);
    end while (!done && lat < 30);
    check($sformatf("lat_%0d", v), lat, 9);
    check($sformatf("busy_cycles_%0d", v), nb, 8);
    check($sformatf("bcd_%0d", v), bcd, exp);
    @(negedge clk);
    check($sformatf("done_width_%0d", v), done, 0);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask
  initial begin
    int n, n0, nd;
    logic [11:0] ref_bcd;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 12'h000);
    rst = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("idle_no_done", nd, 0);
    check("idle_bcd", bcd, 12'h000);
    run(8'd255, 12'h255);
    run(8'd0,   12'h000);
    run(8'd9,   12'h009);
    run(8'd10,  12'h010);
    run(8'd99,  12'h099);
    run(8'd100, 12'h100);
    run(8'd128, 12'h128);
    bin = 8'd42;
    start = 1'b1;
    wait_done(n);
    check("cont_first_lat", n, 9);
    check("cont_first_bcd", bcd, 12'h042);
    repeat (3) @(negedge clk);
    check("cont_busy_mid", busy, 1);
    bin = 8'd7;
    wait_done(n0);
    check("cont_period_a", n0 + 3, 10);
    check("cont_bcd_42", bcd, 12'h042);
    wait_done(n);
    check("cont_period_b", n, 10);
    check("cont_bcd_7", bcd, 12'h007);
    start = 1'b0;
    @(negedge clk);
    check("cont_done_drop", done, 0);
    @(negedge clk);
    bin = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bcd", bcd, 12'h000);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("mid_no_done", nd, 0);
    check("mid_bcd_hold", bcd, 12'h000);
    for (int v = 0; v < 256; v++) begin
      ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run(8'(v), ref_bcd);
      check($sformatf("digits_ok_%0d", v),
            (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
